// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the PC sequencer
package pc_pkg;

    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    function automatic logic pc_misaligned(input logic [PC_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_adder.sv
// rtl/pc_adder.sv - sequential PC incrementer, wraps modulo 2^32
module pc_adder
    import pc_pkg::*;
(
    input  logic [PC_W-1:0] pc_i,
    output logic [PC_W-1:0] sum_o
);

    assign sum_o = pc_i + PC_INC;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter, redirect priority mux, stall/flush control
// Optional: PC_MISALIGN_TRAP_EN traps misaligned branch/jump targets and adds misalign_o.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        halt_i,
    input  logic        resume_i,
    input  logic        jmp_i,
    input  logic [31:0] jmp_tgt_i,
    input  logic        br_i,
    input  logic [31:0] br_tgt_i,
    input  logic        exc_i,
`ifdef PC_MISALIGN_TRAP_EN
    output logic        misalign_o,
`endif
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        fetch_vld_o,
    output logic        flush_ifid_o,
    output logic        flush_idex_o
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [31:0] jmp_sel_tgt;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misalign_q, misalign_d;
`endif

    pc_adder u_pc_adder (
        .pc_i  (pc_q),
        .sum_o (pc_plus4_o)
    );

    // A live ID jump always supersedes an older latched one.
    assign jmp_sel_tgt = jmp_i ? jmp_tgt_i : pend_tgt_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_vld_d   = pend_vld_q;
        pend_tgt_d   = pend_tgt_q;
        fetch_vld_o  = 1'b0;
        flush_ifid_o = 1'b0;
        flush_idex_o = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        misalign_d   = 1'b0;
`endif
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                fetch_vld_o = 1'b1;
                state_d     = halt_i ? ST_HALT : ST_RUN;
                if (exc_i) begin
                    pc_d         = TRAP_VECTOR;
                    flush_ifid_o = 1'b1;
                    flush_idex_o = 1'b1;
                    pend_vld_d   = 1'b0;
                    state_d      = ST_RUN;
                end else if (br_i) begin
                    pc_d         = br_tgt_i;
                    flush_ifid_o = 1'b1;
                    flush_idex_o = 1'b1;
                    pend_vld_d   = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
                    if (pc_misaligned(br_tgt_i)) begin
                        pc_d       = TRAP_VECTOR;
                        misalign_d = 1'b1;
                    end
`endif
                end else if ((jmp_i || pend_vld_q) && !stall_i) begin
                    pc_d         = jmp_sel_tgt;
                    flush_ifid_o = 1'b1;
                    pend_vld_d   = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
                    if (pc_misaligned(jmp_sel_tgt)) begin
                        pc_d         = TRAP_VECTOR;
                        flush_idex_o = 1'b1;
                        misalign_d   = 1'b1;
                    end
`endif
                end else if (jmp_i) begin
                    // Stalled jump: remember it, release when the stall drops.
                    pend_vld_d = 1'b1;
                    pend_tgt_d = jmp_tgt_i;
                end else if (!stall_i) begin
                    pc_d = pc_plus4_o;
                end
            end
            ST_HALT: begin
                if (exc_i) begin
                    pc_d         = TRAP_VECTOR;
                    flush_ifid_o = 1'b1;
                    flush_idex_o = 1'b1;
                    pend_vld_d   = 1'b0;
                    state_d      = ST_RUN;
                end else if (resume_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            pend_vld_q <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_o = misalign_q;
`endif

    assign pc_o = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        halt_i;
    logic        resume_i;
    logic        jmp_i;
    logic [31:0] jmp_tgt_i;
    logic        br_i;
    logic [31:0] br_tgt_i;
    logic        exc_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        fetch_vld_o;
    logic        flush_ifid_o;
    logic        flush_idex_o;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .halt_i       (halt_i),
        .resume_i     (resume_i),
        .jmp_i        (jmp_i),
        .jmp_tgt_i    (jmp_tgt_i),
        .br_i         (br_i),
        .br_tgt_i     (br_tgt_i),
        .exc_i        (exc_i),
`ifdef PC_MISALIGN_TRAP_EN
        .misalign_o   (misalign_o),
`endif
        .pc_o         (pc_o),
        .pc_plus4_o   (pc_plus4_o),
        .fetch_vld_o  (fetch_vld_o),
        .flush_ifid_o (flush_ifid_o),
        .flush_idex_o (flush_idex_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        stall_i   = 1'b0;
        halt_i    = 1'b0;
        resume_i  = 1'b0;
        jmp_i     = 1'b0;
        jmp_tgt_i = 32'h0;
        br_i      = 1'b0;
        br_tgt_i  = 32'h0;
        exc_i     = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Leaves the sequencer in RUN with pc_o = 8.
    task automatic reset_to_pc8();
        apply_reset();
        repeat (3) step();
    endtask

    task automatic test_reset();
        logic [31:0] exp_seq [4];
        exp_seq = '{32'h0, 32'h4, 32'h8, 32'hC};
        apply_reset();
        checks++;
        if (pc_o !== 32'h0 || fetch_vld_o !== 1'b0 || flush_ifid_o !== 1'b0 || flush_idex_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pc=%h vld=%b fl=%b%b, want pc=0 vld=0 fl=00",
                     pc_o, fetch_vld_o, flush_ifid_o, flush_idex_o);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (pc_o !== exp_seq[i] || fetch_vld_o !== 1'b1) begin
                errors++;
                $display("FAIL seq_fetch[%0d]: pc=%h vld=%b, want pc=%h vld=1",
                         i, pc_o, fetch_vld_o, exp_seq[i]);
            end
        end
        checks++;
        if (pc_plus4_o !== 32'h10) begin
            errors++;
            $display("FAIL pc_plus4: got %h, want 00000010", pc_plus4_o);
        end
    endtask

    task automatic test_stall();
        reset_to_pc8();
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (pc_o !== 32'h8 || fetch_vld_o !== 1'b1 || flush_ifid_o !== 1'b0 || flush_idex_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: pc=%h vld=%b fl=%b%b, want pc=8 vld=1 fl=00",
                         i, pc_o, fetch_vld_o, flush_ifid_o, flush_idex_o);
            end
        end
        stall_i = 1'b0;
        step();
        checks++;
        if (pc_o !== 32'hC) begin
            errors++;
            $display("FAIL stall_release: pc=%h, want 0000000c", pc_o);
        end
    endtask

    task automatic test_br_over_jmp();
        reset_to_pc8();
        jmp_i = 1'b1; jmp_tgt_i = 32'h40;
        br_i  = 1'b1; br_tgt_i  = 32'h80;
        #1;
        checks++;
        if (flush_ifid_o !== 1'b1 || flush_idex_o !== 1'b1) begin
            errors++;
            $display("FAIL br_jmp_flush: fl=%b%b, want 11", flush_ifid_o, flush_idex_o);
        end
        step();
        clear_inputs();
        checks++;
        if (pc_o !== 32'h80) begin
            errors++;
            $display("FAIL br_jmp_pc: pc=%h, want 00000080", pc_o);
        end
    endtask

    task automatic test_pending_jmp();
        reset_to_pc8();
        stall_i = 1'b1; jmp_i = 1'b1; jmp_tgt_i = 32'h100;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (flush_ifid_o !== 1'b0 || flush_idex_o !== 1'b0) begin
                errors++;
                $display("FAIL pend_stall_flush[%0d]: fl=%b%b, want 00", i, flush_ifid_o, flush_idex_o);
            end
            step();
            checks++;
            if (pc_o !== 32'h8) begin
                errors++;
                $display("FAIL pend_hold[%0d]: pc=%h, want 00000008", i, pc_o);
            end
        end
        clear_inputs();
        #1;
        checks++;
        if (flush_ifid_o !== 1'b1 || flush_idex_o !== 1'b0) begin
            errors++;
            $display("FAIL pend_release_flush: fl=%b%b, want 10", flush_ifid_o, flush_idex_o);
        end
        step();
        checks++;
        if (pc_o !== 32'h100 || flush_ifid_o !== 1'b0) begin
            errors++;
            $display("FAIL pend_apply: pc=%h flush_ifid=%b, want pc=00000100 flush_ifid=0",
                     pc_o, flush_ifid_o);
        end
        step();
        checks++;
        if (pc_o !== 32'h104) begin
            errors++;
            $display("FAIL pend_after: pc=%h, want 00000104", pc_o);
        end
    endtask

    task automatic test_exc_halt();
        reset_to_pc8();
        stall_i = 1'b1; exc_i = 1'b1;
        #1;
        checks++;
        if (flush_ifid_o !== 1'b1 || flush_idex_o !== 1'b1) begin
            errors++;
            $display("FAIL exc_stall_flush: fl=%b%b, want 11", flush_ifid_o, flush_idex_o);
        end
        step();
        clear_inputs();
        checks++;
        if (pc_o !== 32'h4) begin
            errors++;
            $display("FAIL exc_stall_pc: pc=%h, want 00000004", pc_o);
        end
        halt_i = 1'b1;
        step();
        halt_i = 1'b0;
        checks++;
        if (fetch_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL halt_enter: vld=%b, want 0", fetch_vld_o);
        end
        step();
        checks++;
        if (pc_o !== 32'h8 || fetch_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL halt_hold: pc=%h vld=%b, want pc=00000008 vld=0", pc_o, fetch_vld_o);
        end
        exc_i = 1'b1;
        #1;
        checks++;
        if (flush_ifid_o !== 1'b1 || flush_idex_o !== 1'b1) begin
            errors++;
            $display("FAIL exc_halt_flush: fl=%b%b, want 11", flush_ifid_o, flush_idex_o);
        end
        step();
        clear_inputs();
        checks++;
        if (pc_o !== 32'h4 || fetch_vld_o !== 1'b1) begin
            errors++;
            $display("FAIL exc_halt_wake: pc=%h vld=%b, want pc=00000004 vld=1", pc_o, fetch_vld_o);
        end
        halt_i = 1'b1;
        step();
        halt_i = 1'b0; resume_i = 1'b1;
        step();
        resume_i = 1'b0;
        checks++;
        if (pc_o !== 32'h8 || fetch_vld_o !== 1'b1) begin
            errors++;
            $display("FAIL resume: pc=%h vld=%b, want pc=00000008 vld=1", pc_o, fetch_vld_o);
        end
    endtask

    task automatic test_wrap_misalign();
        reset_to_pc8();
        br_i = 1'b1; br_tgt_i = 32'hFFFF_FFFC;
        step();
        clear_inputs();
        checks++;
        if (pc_o !== 32'hFFFF_FFFC || pc_plus4_o !== 32'h0) begin
            errors++;
            $display("FAIL wrap_plus4: pc=%h plus4=%h, want fffffffc / 00000000", pc_o, pc_plus4_o);
        end
        step();
        checks++;
        if (pc_o !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc: pc=%h, want 00000000", pc_o);
        end
        br_i = 1'b1; br_tgt_i = 32'h42;
        step();
        clear_inputs();
`ifdef PC_MISALIGN_TRAP_EN
        checks++;
        if (pc_o !== 32'h4 || misalign_o !== 1'b1) begin
            errors++;
            $display("FAIL misalign_trap: pc=%h mis=%b, want pc=00000004 mis=1", pc_o, misalign_o);
        end
        step();
        checks++;
        if (misalign_o !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pulse: mis=%b, want 0", misalign_o);
        end
`else
        checks++;
        if (pc_o !== 32'h42) begin
            errors++;
            $display("FAIL br_verbatim: pc=%h, want 00000042", pc_o);
        end
`endif
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_stall();
        test_br_over_jmp();
        test_pending_jmp();
        test_exc_halt();
        test_wrap_misalign();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
